// File: rtl/imem_loader.sv
// imem_loader: streams big-endian program bytes into 32-bit instruction-memory writes, holding the CPU in reset until done
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, word_count   one-cycle load request and number of words, sampled in IDLE
//   rx_valid, rx_byte   inbound byte stream
//   rx_ready            byte accepted on this edge when rx_valid is also high
//   mem_we, mem_addr,   one-cycle write strobe with word-aligned byte address
//   mem_wdata           and the assembled word
//   busy, done          load in progress / load complete
//   cpu_reset           datapath held in reset until the load completes
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  word_count,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        cpu_reset
);
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
    state_t     state;
    logic [7:0] count;
    logic [7:0] words;
    logic [1:0] idx;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 8'd0;
            words     <= 8'd0;
            idx       <= 2'd0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= 32'd0;
            rx_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cpu_reset <= 1'b1;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    count    <= word_count;
                    words    <= 8'd0;
                    idx      <= 2'd0;
                    mem_addr <= BASE_ADDR;
                    if (word_count == 8'd0) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                    end else begin
                        state    <= RECV;
                        rx_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                // mem_wdata doubles as the shift register: four shifts replace every byte of the previous word
                RECV: if (rx_valid && rx_ready) begin
                    mem_wdata <= {mem_wdata[23:0], rx_byte};
                    idx       <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state    <= WRITE;
                        mem_we   <= 1'b1;
                        rx_ready <= 1'b0;
                    end
                end
                WRITE: begin
                    mem_addr <= mem_addr + 32'd4;
                    words    <= words + 8'd1;
                    if (words + 8'd1 == count) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                    end else begin
                        state    <= RECV;
                        rx_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader (default base and wrapping base instances)
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  word_count = 8'd0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic        rx_ready, mem_we, busy, done, cpu_reset;
    logic [31:0] mem_addr, mem_wdata;
    logic        rx_ready2, mem_we2, busy2, done2, cpu_reset2;
    logic [31:0] mem_addr2, mem_wdata2;
    logic [63:0] log1[$];
    logic [63:0] log2[$];
    int checks = 0;
    int errors = 0;

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .cpu_reset(cpu_reset)
    );

    imem_loader #(.BASE_ADDR(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rx_ready2),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .busy(busy2), .done(done2), .cpu_reset(cpu_reset2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) log1.push_back({mem_addr, mem_wdata});
        if (mem_we2) log2.push_back({mem_addr2, mem_wdata2});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        log1.delete();
        log2.delete();
    endtask

    task automatic pulse_start(input logic [7:0] wc);
        start = 1'b1;
        word_count = wc;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        logic acc;
        rx_valid = 1'b1;
        rx_byte = b;
        do begin
            acc = rx_ready;
            cyc(1);
            n++;
        end while (!acc && n < 50);
        chk("byte_accept", {31'd0, acc}, 32'd1);
    endtask

    // rx_valid stays high after the last byte, so the held byte is re-offered during WRITE
    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31 - 8*i -: 8]);
            if (gaps && i < 3) begin
                rx_valid = 1'b0;
                cyc($urandom_range(0, 3));
            end
        end
    endtask

    initial begin
        cyc(2);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_addr2", mem_addr2, 32'hFFFF_FFFC);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);

        // single word
        do_reset();
        cyc(1);
        chk("idle_rx_ready", {31'd0, rx_ready}, 32'd0);
        pulse_start(8'd1);
        chk("recv_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("recv_busy", {31'd0, busy}, 32'd1);
        chk("recv_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        send_word(32'h2008_0005, 1'b0);
        chk("w1_we", {31'd0, mem_we}, 32'd1);
        chk("w1_addr", mem_addr, 32'h0);
        chk("w1_data", mem_wdata, 32'h2008_0005);
        chk("w1_rx_ready", {31'd0, rx_ready}, 32'd0);
        cyc(1);
        chk("w1_done", {31'd0, done}, 32'd1);
        chk("w1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("w1_busy", {31'd0, busy}, 32'd0);
        chk("w1_we_low", {31'd0, mem_we}, 32'd0);
        cyc(4);
        chk("done_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("done_sticky", {31'd0, done}, 32'd1);
        chk("w1_pulses", log1.size(), 32'd1);
        if (log1.size() > 0) chk("w1_log", log1[0][31:0], 32'h2008_0005);
        rx_valid = 1'b0;

        // zero count
        do_reset();
        pulse_start(8'd0);
        chk("z_done", {31'd0, done}, 32'd1);
        chk("z_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("z_busy", {31'd0, busy}, 32'd0);
        chk("z_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        cyc(3);
        chk("z_pulses", log1.size(), 32'd0);

        // three words with gaps, start pulsed in RECV, rx_valid held through WRITE
        do_reset();
        pulse_start(8'd3);
        send_byte(8'h11);
        send_byte(8'h22);
        rx_valid = 1'b0;
        pulse_start(8'd1);
        cyc(2);
        send_byte(8'h33);
        send_byte(8'h44);
        send_word(32'h5566_7788, 1'b1);
        send_word(32'h99AA_BBCC, 1'b1);
        cyc(4);
        rx_valid = 1'b0;
        chk("m_done", {31'd0, done}, 32'd1);
        chk("m_pulses", log1.size(), 32'd3);
        if (log1.size() == 3) begin
            chk("m_addr0", log1[0][63:32], 32'h0);
            chk("m_data0", log1[0][31:0], 32'h1122_3344);
            chk("m_addr1", log1[1][63:32], 32'h4);
            chk("m_data1", log1[1][31:0], 32'h5566_7788);
            chk("m_addr2", log1[2][63:32], 32'h8);
            chk("m_data2", log1[2][31:0], 32'h99AA_BBCC);
        end

        // reset in the middle of the second word, with rx_valid still high
        do_reset();
        pulse_start(8'd3);
        send_word(32'hAABB_CCDD, 1'b0);
        send_byte(8'h01);
        send_byte(8'h02);
        start = 1'b1;
        word_count = 8'd1;
        do_reset();
        start = 1'b0;
        rx_valid = 1'b0;
        chk("mr_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("mr_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_we", {31'd0, mem_we}, 32'd0);
        chk("mr_wdata", mem_wdata, 32'h0);
        cyc(2);
        chk("mr_idle_busy", {31'd0, busy}, 32'd0);
        pulse_start(8'd1);
        send_word(32'h0304_0506, 1'b1);
        rx_valid = 1'b0;
        cyc(2);
        chk("mr_pulses", log1.size(), 32'd1);
        if (log1.size() == 1) begin
            chk("mr_addr", log1[0][63:32], 32'h0);
            chk("mr_data", log1[0][31:0], 32'h0304_0506);
        end
        chk("mr_done", {31'd0, done}, 32'd1);

        // wrap on the high-base instance
        do_reset();
        pulse_start(8'd2);
        send_word(32'h0102_0304, 1'b1);
        send_word(32'h0506_0708, 1'b1);
        rx_valid = 1'b0;
        cyc(2);
        chk("wr_done", {31'd0, done2}, 32'd1);
        chk("wr_pulses", log2.size(), 32'd2);
        if (log2.size() == 2) begin
            chk("wr_addr0", log2[0][63:32], 32'hFFFF_FFFC);
            chk("wr_data0", log2[0][31:0], 32'h0102_0304);
            chk("wr_addr1", log2[1][63:32], 32'h0000_0000);
            chk("wr_data1", log2[1][31:0], 32'h0506_0708);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
